int_issue_queue: RTL and testbench

Integer issue queue and writeback register sitting between decode and the integer execution unit. It buffers decoded integer operations (micro-opcode, two operand words, destination register) in a small in-order FIFO and drives the exec unit's operand, micro-opcode and enable lines from the head entry. It also captures the exec unit's combinational result into a writeback register with a valid/ready handshake toward the register-file write port. The exec unit itself is instantiated beside this block, not inside it.

---
 rtl/int_issue_queue_pkg.sv | 21 ++
 rtl/int_issue_queue_fifo.sv | 94 +++++++++
 rtl/int_issue_queue.sv | 102 ++++++++++
 tb/tb_int_issue_queue.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_issue_queue_pkg.sv
// Shared integer-core definitions: micro-opcode encodings understood by the
// integer exec unit and default field widths used by the issue queue.
package core101_int_pkg;

    localparam int UOP_WIDTH              = 4;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;

    localparam logic [UOP_WIDTH-1:0] UOP_ADD     = 4'b0000;
    localparam logic [UOP_WIDTH-1:0] UOP_SUB     = 4'b0001;
    localparam logic [UOP_WIDTH-1:0] UOP_OR      = 4'b0010;
    localparam logic [UOP_WIDTH-1:0] UOP_AND     = 4'b0011;
    localparam logic [UOP_WIDTH-1:0] UOP_XOR     = 4'b0100;
    localparam logic [UOP_WIDTH-1:0] UOP_BUF_RS1 = 4'b1000;
    localparam logic [UOP_WIDTH-1:0] UOP_BUF_RS2 = 4'b1001;
    localparam logic [UOP_WIDTH-1:0] UOP_SLT     = 4'b1010;
    localparam logic [UOP_WIDTH-1:0] UOP_SLTU    = 4'b1011;
    localparam logic [UOP_WIDTH-1:0] UOP_SRA     = 4'b1101;
    localparam logic [UOP_WIDTH-1:0] UOP_SRL     = 4'b1110;
    localparam logic [UOP_WIDTH-1:0] UOP_SLL     = 4'b1111;

endpackage

// File: rtl/int_issue_queue_fifo.sv
// In-order DEPTH-entry FIFO of decoded integer ops {uop, a, b, rd}.
// Push is ignored when full, pop is ignored when empty; flush empties the
// queue and overrides any push/pop in the same cycle.
module int_issue_fifo
    import core101_int_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [UOP_WIDTH-1:0]         i_uop,
    input  logic [DATA_WIDTH-1:0]        i_a,
    input  logic [DATA_WIDTH-1:0]        i_b,
    input  logic [REG_ADDR_WIDTH-1:0]    i_rd,
    output logic [UOP_WIDTH-1:0]         o_uop,
    output logic [DATA_WIDTH-1:0]        o_a,
    output logic [DATA_WIDTH-1:0]        o_b,
    output logic [REG_ADDR_WIDTH-1:0]    o_rd,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [UOP_WIDTH-1:0]      r_uop_mem [DEPTH];
    logic [DATA_WIDTH-1:0]     r_a_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]     r_b_mem   [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] r_rd_mem  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    // Payload storage: written at the tail on an accepted push, never reset.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush && !i_rst) begin
            r_uop_mem[r_wr_ptr] <= i_uop;
            r_a_mem[r_wr_ptr]   <= i_a;
            r_b_mem[r_wr_ptr]   <= i_b;
            r_rd_mem[r_wr_ptr]  <= i_rd;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    assign o_uop   = r_uop_mem[r_rd_ptr];
    assign o_a     = r_a_mem[r_rd_ptr];
    assign o_b     = r_b_mem[r_rd_ptr];
    assign o_rd    = r_rd_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: buffers decoded ops, presents the head op to the
// external exec unit, and captures its combinational result into a
// writeback register handshaked toward the register-file write port.
// Ops targeting x0 are issued and popped but their result is dropped.
module int_issue_queue
    import core101_int_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         flush_in,
    input  logic                         dec_valid_in,
    output logic                         dec_ready_out,
    input  logic [UOP_WIDTH-1:0]         dec_uop_in,
    input  logic [DATA_WIDTH-1:0]        dec_a_data_in,
    input  logic [DATA_WIDTH-1:0]        dec_b_data_in,
    input  logic [REG_ADDR_WIDTH-1:0]    dec_rd_in,
    output logic                         exec_enable_out,
    output logic [UOP_WIDTH-1:0]         exec_uop_out,
    output logic [DATA_WIDTH-1:0]        exec_a_data_out,
    output logic [DATA_WIDTH-1:0]        exec_b_data_out,
    input  logic [DATA_WIDTH-1:0]        exec_res_data_in,
    output logic                         wb_valid_out,
    input  logic                         wb_ready_in,
    output logic [REG_ADDR_WIDTH-1:0]    wb_rd_out,
    output logic [DATA_WIDTH-1:0]        wb_data_out,
    output logic [$clog2(DEPTH):0]       count_out
);

    logic [UOP_WIDTH-1:0]      w_head_uop;
    logic [DATA_WIDTH-1:0]     w_head_a;
    logic [DATA_WIDTH-1:0]     w_head_b;
    logic [REG_ADDR_WIDTH-1:0] w_head_rd;
    logic [$clog2(DEPTH):0]    w_count;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_issue;
    logic                      w_wb_free;

    logic                      r_wb_valid;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
    logic [DATA_WIDTH-1:0]     r_wb_data;

    int_issue_fifo #(
        .DATA_WIDTH     (DATA_WIDTH),
        .DEPTH          (DEPTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fifo (
        .i_clk   (clock_in),
        .i_rst   (reset_in),
        .i_flush (flush_in),
        .i_push  (dec_valid_in),
        .i_pop   (w_issue),
        .i_uop   (dec_uop_in),
        .i_a     (dec_a_data_in),
        .i_b     (dec_b_data_in),
        .i_rd    (dec_rd_in),
        .o_uop   (w_head_uop),
        .o_a     (w_head_a),
        .o_b     (w_head_b),
        .o_rd    (w_head_rd),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // The writeback slot is free if empty or being drained this cycle, so
    // issue is the only path that depends combinationally on wb_ready_in.
    assign w_wb_free = !r_wb_valid || wb_ready_in;
    assign w_issue   = !w_empty && w_wb_free;

    // Writeback register: load on issue of a non-x0 op, clear on drain.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else if (flush_in) begin
            r_wb_valid <= 1'b0;
        end else if (w_issue && (w_head_rd != '0)) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= w_head_rd;
            r_wb_data  <= exec_res_data_in;
        end else if (r_wb_valid && wb_ready_in) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign dec_ready_out   = !w_full;
    assign exec_enable_out = w_issue;
    assign exec_uop_out    = w_empty ? '0 : w_head_uop;
    assign exec_a_data_out = w_empty ? '0 : w_head_a;
    assign exec_b_data_out = w_empty ? '0 : w_head_b;
    assign wb_valid_out    = r_wb_valid;
    assign wb_rd_out       = r_wb_rd;
    assign wb_data_out     = r_wb_data;
    assign count_out       = w_count;

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: acts as the exec unit, runs directed scenarios
// and a randomized run checked against an op-level reference queue.
module tb_int_issue_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int RW    = 5;

    typedef struct {
        logic [3:0]    uop;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] rd;
    } op_t;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic          flush_in;
    logic          dec_valid_in;
    logic          dec_ready_out;
    logic [3:0]    dec_uop_in;
    logic [DW-1:0] dec_a_data_in;
    logic [DW-1:0] dec_b_data_in;
    logic [RW-1:0] dec_rd_in;
    logic          exec_enable_out;
    logic [3:0]    exec_uop_out;
    logic [DW-1:0] exec_a_data_out;
    logic [DW-1:0] exec_b_data_out;
    logic [DW-1:0] exec_res_data_in;
    logic          wb_valid_out;
    logic          wb_ready_in;
    logic [RW-1:0] wb_rd_out;
    logic [DW-1:0] wb_data_out;
    logic [2:0]    count_out;

    int total = 0;
    int bad   = 0;

    // reference model state
    op_t           m_q[$];
    logic          m_wbv  = 1'b0;
    logic [RW-1:0] m_rd   = '0;
    logic [DW-1:0] m_data = '0;

    int_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .REG_ADDR_WIDTH(RW)) dut (
        .clock_in         (clock_in),
        .reset_in         (reset_in),
        .flush_in         (flush_in),
        .dec_valid_in     (dec_valid_in),
        .dec_ready_out    (dec_ready_out),
        .dec_uop_in       (dec_uop_in),
        .dec_a_data_in    (dec_a_data_in),
        .dec_b_data_in    (dec_b_data_in),
        .dec_rd_in        (dec_rd_in),
        .exec_enable_out  (exec_enable_out),
        .exec_uop_out     (exec_uop_out),
        .exec_a_data_out  (exec_a_data_out),
        .exec_b_data_out  (exec_b_data_out),
        .exec_res_data_in (exec_res_data_in),
        .wb_valid_out     (wb_valid_out),
        .wb_ready_in      (wb_ready_in),
        .wb_rd_out        (wb_rd_out),
        .wb_data_out      (wb_data_out),
        .count_out        (count_out)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [DW-1:0] alu(input logic [3:0] u, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (u)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a | b;
            4'b0011: r = a & b;
            4'b0100: r = a ^ b;
            4'b1000: r = a;
            4'b1001: r = b;
            4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: r = (a < b) ? 32'd1 : 32'd0;
            4'b1101: r = DW'($signed(a) >>> b[4:0]);
            4'b1110: r = a >> b[4:0];
            4'b1111: r = a << b[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    // the bench plays the exec unit
    assign exec_res_data_in = alu(exec_uop_out, exec_a_data_out, exec_b_data_out);

    // advance the reference model with the current inputs, then take one clock edge
    task automatic step();
        op_t h;
        op_t n;
        bit  do_issue;
        bit  do_push;
        if (reset_in) begin
            m_q.delete();
            m_wbv  = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else if (flush_in) begin
            m_q.delete();
            m_wbv = 1'b0;
        end else begin
            do_issue = (m_q.size() != 0) && (!m_wbv || wb_ready_in);
            do_push  = dec_valid_in && (m_q.size() != DEPTH);
            n.uop = dec_uop_in; n.a = dec_a_data_in; n.b = dec_b_data_in; n.rd = dec_rd_in;
            if (do_issue) begin
                h = m_q.pop_front();
                if (h.rd != 0) begin
                    m_wbv  = 1'b1;
                    m_rd   = h.rd;
                    m_data = alu(h.uop, h.a, h.b);
                end else if (wb_ready_in) begin
                    m_wbv = 1'b0;
                end
            end else if (m_wbv && wb_ready_in) begin
                m_wbv = 1'b0;
            end
            if (do_push) m_q.push_back(n);
        end
        @(posedge clock_in);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] u, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [RW-1:0] rd);
        dec_valid_in  = 1'b1;
        dec_uop_in    = u;
        dec_a_data_in = a;
        dec_b_data_in = b;
        dec_rd_in     = rd;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        step();
        step();
        reset_in = 1'b0;
        total++; if (count_out !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count_out); end
        total++; if (dec_ready_out !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", dec_ready_out); end
        total++; if (exec_enable_out !== 1'b0) begin bad++; $display("FAIL rst_exec_en got=%b exp=0", exec_enable_out); end
        total++; if ({exec_uop_out, exec_a_data_out, exec_b_data_out} !== '0) begin
            bad++; $display("FAIL rst_exec_bus got=%h/%h/%h exp=0", exec_uop_out, exec_a_data_out, exec_b_data_out); end
        total++; if ({wb_valid_out, wb_rd_out, wb_data_out} !== '0) begin
            bad++; $display("FAIL rst_wb got=%b/%0d/%h exp=0/0/0", wb_valid_out, wb_rd_out, wb_data_out); end
    endtask

    task automatic test_single();
        wb_ready_in = 1'b1;
        drive_op(4'b0000, 32'd5, 32'd7, 5'd3);
        step();
        dec_valid_in = 1'b0;
        total++; if (exec_enable_out !== 1'b1 || exec_a_data_out !== 32'd5 || exec_b_data_out !== 32'd7 || exec_uop_out !== 4'b0000) begin
            bad++; $display("FAIL single_issue got en=%b uop=%h a=%0d b=%0d exp en=1 uop=0 a=5 b=7",
                            exec_enable_out, exec_uop_out, exec_a_data_out, exec_b_data_out); end
        total++; if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL single_early_wb got=%b exp=0", wb_valid_out); end
        step();
        total++; if (wb_valid_out !== 1'b1 || wb_rd_out !== 5'd3 || wb_data_out !== 32'd12) begin
            bad++; $display("FAIL single_wb got=%b/%0d/%0d exp=1/3/12", wb_valid_out, wb_rd_out, wb_data_out); end
        total++; if (exec_enable_out !== 1'b0 || count_out !== 3'd0) begin
            bad++; $display("FAIL single_after got en=%b cnt=%0d exp en=0 cnt=0", exec_enable_out, count_out); end
        step();
        total++; if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", wb_valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] erd [3];
        logic [DW-1:0] edat [3];
        erd[0] = 5'd1; erd[1] = 5'd2; erd[2] = 5'd4;
        edat[0] = 32'd6; edat[1] = 32'h0F; edat[2] = 32'd16;
        wb_ready_in = 1'b1;
        drive_op(4'b0001, 32'd10, 32'd4, 5'd1);
        step();
        drive_op(4'b0100, 32'hF0, 32'hFF, 5'd2);
        step();
        total++; if (wb_valid_out !== 1'b1 || wb_rd_out !== erd[0] || wb_data_out !== edat[0]) begin
            bad++; $display("FAIL b2b_0 got=%b/%0d/%h exp=1/%0d/%h", wb_valid_out, wb_rd_out, wb_data_out, erd[0], edat[0]); end
        drive_op(4'b1111, 32'd1, 32'd4, 5'd4);
        step();
        dec_valid_in = 1'b0;
        total++; if (wb_valid_out !== 1'b1 || wb_rd_out !== erd[1] || wb_data_out !== edat[1]) begin
            bad++; $display("FAIL b2b_1 got=%b/%0d/%h exp=1/%0d/%h", wb_valid_out, wb_rd_out, wb_data_out, erd[1], edat[1]); end
        step();
        total++; if (wb_valid_out !== 1'b1 || wb_rd_out !== erd[2] || wb_data_out !== edat[2]) begin
            bad++; $display("FAIL b2b_2 got=%b/%0d/%h exp=1/%0d/%h", wb_valid_out, wb_rd_out, wb_data_out, erd[2], edat[2]); end
        step();
        total++; if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", wb_valid_out); end
    endtask

    task automatic test_backpressure();
        wb_ready_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive_op(4'b0000, DW'(i), 32'd100, RW'(i));
            step();
        end
        total++; if (count_out !== 3'd4 || dec_ready_out !== 1'b0) begin
            bad++; $display("FAIL bp_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", count_out, dec_ready_out); end
        total++; if (wb_valid_out !== 1'b1 || wb_rd_out !== 5'd1 || wb_data_out !== 32'd101 || exec_enable_out !== 1'b0) begin
            bad++; $display("FAIL bp_hold got=%b/%0d/%0d en=%b exp=1/1/101 en=0", wb_valid_out, wb_rd_out, wb_data_out, exec_enable_out); end
        drive_op(4'b0000, 32'd6, 32'd100, 5'd6);
        step();
        dec_valid_in = 1'b0;
        total++; if (count_out !== 3'd4) begin bad++; $display("FAIL bp_reject got=%0d exp=4", count_out); end
        wb_ready_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            total++; if (wb_valid_out !== 1'b1 || wb_rd_out !== RW'(k) || wb_data_out !== DW'(100 + k)) begin
                bad++; $display("FAIL bp_drain%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, wb_valid_out, wb_rd_out, wb_data_out, k, 100 + k); end
            step();
        end
        total++; if (wb_valid_out !== 1'b0 || count_out !== 3'd0) begin
            bad++; $display("FAIL bp_end got v=%b cnt=%0d exp v=0 cnt=0", wb_valid_out, count_out); end
    endtask

    task automatic test_x0_drop();
        wb_ready_in = 1'b1;
        drive_op(4'b0000, 32'd1, 32'd1, 5'd0);
        step();
        drive_op(4'b0000, 32'd2, 32'd2, 5'd6);
        step();
        dec_valid_in = 1'b0;
        total++; if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL x0_dropped got=%b exp=0", wb_valid_out); end
        step();
        total++; if (wb_valid_out !== 1'b1 || wb_rd_out !== 5'd6 || wb_data_out !== 32'd4) begin
            bad++; $display("FAIL x0_next got=%b/%0d/%0d exp=1/6/4", wb_valid_out, wb_rd_out, wb_data_out); end
        step();
        total++; if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL x0_end got=%b exp=0", wb_valid_out); end
    endtask

    task automatic test_flush();
        wb_ready_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_op(4'b0010, DW'(i), 32'h10, RW'(i + 10));
            step();
        end
        total++; if (count_out !== 3'd3 || wb_valid_out !== 1'b1) begin
            bad++; $display("FAIL fl_pre got cnt=%0d v=%b exp cnt=3 v=1", count_out, wb_valid_out); end
        flush_in = 1'b1;
        drive_op(4'b0000, 32'd9, 32'd9, 5'd20);
        step();
        flush_in = 1'b0;
        dec_valid_in = 1'b0;
        total++; if (count_out !== 3'd0 || wb_valid_out !== 1'b0 || dec_ready_out !== 1'b1 || exec_enable_out !== 1'b0) begin
            bad++; $display("FAIL fl_post got cnt=%0d v=%b rdy=%b en=%b exp 0/0/1/0", count_out, wb_valid_out, dec_ready_out, exec_enable_out); end
        wb_ready_in = 1'b1;
        step();
        step();
        total++; if (count_out !== 3'd0 || wb_valid_out !== 1'b0) begin
            bad++; $display("FAIL fl_absent got cnt=%0d v=%b exp 0/0", count_out, wb_valid_out); end
    endtask

    task automatic test_reset_mid();
        wb_ready_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive_op(4'b0011, 32'hFF, DW'(i), RW'(i));
            step();
        end
        dec_valid_in = 1'b0;
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        total++; if (count_out !== 3'd0 || dec_ready_out !== 1'b1 || exec_enable_out !== 1'b0 ||
                     {wb_valid_out, wb_rd_out, wb_data_out} !== '0) begin
            bad++; $display("FAIL rm_reset got cnt=%0d rdy=%b en=%b wb=%b/%0d/%0d exp 0/1/0 0/0/0",
                            count_out, dec_ready_out, exec_enable_out, wb_valid_out, wb_rd_out, wb_data_out); end
        wb_ready_in = 1'b1;
        drive_op(4'b0000, 32'd3, 32'd4, 5'd9);
        step();
        dec_valid_in = 1'b0;
        step();
        total++; if (wb_valid_out !== 1'b1 || wb_rd_out !== 5'd9 || wb_data_out !== 32'd7) begin
            bad++; $display("FAIL rm_after got=%b/%0d/%0d exp=1/9/7", wb_valid_out, wb_rd_out, wb_data_out); end
        step();
    endtask

    task automatic test_random();
        logic [3:0]    eu;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        for (int c = 0; c < 600; c++) begin
            reset_in     = ($urandom_range(0, 199) == 0);
            flush_in     = ($urandom_range(0, 39) == 0);
            wb_ready_in  = ($urandom_range(0, 9) < 6);
            drive_op(4'($urandom_range(0, 15)), $urandom, 32'($urandom_range(0, 40)), RW'($urandom_range(0, 31)));
            dec_valid_in = ($urandom_range(0, 9) < 7);
            #1;
            eu = (m_q.size() != 0) ? m_q[0].uop : 4'd0;
            ea = (m_q.size() != 0) ? m_q[0].a : '0;
            eb = (m_q.size() != 0) ? m_q[0].b : '0;
            total++;
            if (count_out !== 3'(m_q.size()) || dec_ready_out !== (m_q.size() != DEPTH) ||
                exec_enable_out !== ((m_q.size() != 0) && (!m_wbv || wb_ready_in)) ||
                exec_uop_out !== eu || exec_a_data_out !== ea || exec_b_data_out !== eb) begin
                bad++;
                $display("FAIL rand_queue c=%0d got cnt=%0d rdy=%b en=%b uop=%h a=%h b=%h exp cnt=%0d uop=%h a=%h b=%h",
                         c, count_out, dec_ready_out, exec_enable_out, exec_uop_out, exec_a_data_out,
                         exec_b_data_out, m_q.size(), eu, ea, eb);
            end
            total++;
            if (wb_valid_out !== m_wbv || wb_rd_out !== m_rd || wb_data_out !== m_data) begin
                bad++;
                $display("FAIL rand_wb c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, wb_valid_out, wb_rd_out,
                         wb_data_out, m_wbv, m_rd, m_data);
            end
            step();
        end
        reset_in = 1'b0;
        flush_in = 1'b0;
        dec_valid_in = 1'b0;
    endtask

    initial begin
        reset_in      = 1'b1;
        flush_in      = 1'b0;
        dec_valid_in  = 1'b0;
        dec_uop_in    = '0;
        dec_a_data_in = '0;
        dec_b_data_in = '0;
        dec_rd_in     = '0;
        wb_ready_in   = 1'b0;
        @(posedge clock_in);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_x0_drop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
